// File: rtl/sd_stream_loader_if.sv
// Bus bundle between the SD stream loader, the SdCardCtrl byte port and the RAM write arbiter.
// Handshakes: sd_rd/sd_addr hold until sd_busy rises; each byte is a 4-phase
// sd_hndshk_i/sd_hndshk_o exchange; ram_we holds address/data until ram_op_begun.
interface sd_stream_loader_if #(
    parameter int ADDR_W     = 25,
    parameter int WORD_BYTES = 2
);
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_address;
    logic [8*WORD_BYTES-1:0]   ram_data;
    logic                      ram_op_begun;
    logic                      sd_rd;
    logic                      sd_continue;
    logic [31:0]               sd_addr;
    logic [7:0]                sd_data;
    logic                      sd_busy;
    logic                      sd_hndshk_i;
    logic                      sd_hndshk_o;
    logic [15:0]               sd_error;

    modport master (
        output ram_we, ram_address, ram_data, sd_rd, sd_continue, sd_addr, sd_hndshk_o,
        input  ram_op_begun, sd_data, sd_busy, sd_hndshk_i, sd_error
    );

    modport slave (
        input  ram_we, ram_address, ram_data, sd_rd, sd_continue, sd_addr, sd_hndshk_o,
        output ram_op_begun, sd_data, sd_busy, sd_hndshk_i, sd_error
    );
endinterface

// File: rtl/sd_stream_loader.sv
// Re-triggerable SD-to-RAM loader: streams word_count packed words from src_block onward
// into RAM starting at dst_addr, draining any unused bytes of the last block.
module sd_stream_loader #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 25,
    parameter bit SDHC       = 1'b1,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       src_block,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              ready,
    output logic              done,
    output logic              error,
    output logic [15:0]       err_code,
    output logic [3:0]        state_o,
    sd_stream_loader_if.master bus
);
    localparam int         WW      = 8 * WORD_BYTES;
    localparam logic [1:0] LAST_BI = 2'(WORD_BYTES - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_REQ, S_BYTE_WAIT, S_BYTE_ACK, S_WRITE,
        S_DRAIN, S_DRAIN_ACK, S_FINISH, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       blk_q, blk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [8:0]        bb_q, bb_d;
    logic [1:0]        bi_q, bi_d;
    logic [WW-1:0]     word_q, word_d;
    logic [15:0]       err_q, err_d;
    logic              cont_q, cont_d;
    logic [1:0]        lane;

    assign lane = BIG_ENDIAN ? (LAST_BI - bi_q) : bi_q;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            blk_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            bb_q    <= '0;
            bi_q    <= '0;
            word_q  <= '0;
            err_q   <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            bb_q    <= bb_d;
            bi_q    <= bi_d;
            word_q  <= word_d;
            err_q   <= err_d;
            cont_q  <= cont_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        bb_d    = bb_q;
        bi_d    = bi_q;
        word_d  = word_q;
        err_d   = err_q;
        cont_d  = cont_q;
        case (state_q)
            S_INIT: begin
                if (!bus.sd_busy) begin
                    if (bus.sd_error == 16'h0000) begin
                        state_d = S_IDLE;
                    end else begin
                        err_d   = bus.sd_error;
                        state_d = S_ERROR;
                    end
                end
            end
            S_IDLE: begin
                if (start) begin
                    blk_d   = src_block;
                    addr_d  = dst_addr;
                    rem_d   = word_count;
                    cont_d  = 1'b0;
                    state_d = (word_count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.sd_busy) begin
                    bb_d    = '0;
                    bi_d    = '0;
                    cont_d  = 1'b1;
                    state_d = S_BYTE_WAIT;
                end
            end
            S_BYTE_WAIT: begin
                if (bus.sd_hndshk_i) begin
                    word_d[int'(lane)*8 +: 8] = bus.sd_data;
                    state_d = S_BYTE_ACK;
                end else if (!bus.sd_busy) begin
                    // Busy dropping mid-block means the controller aborted the read.
                    if (bb_q == 9'd0) begin
                        blk_d   = blk_q + 32'd1;
                        state_d = S_REQ;
                    end else begin
                        err_d   = 16'h8000;
                        state_d = S_ERROR;
                    end
                end
            end
            S_BYTE_ACK: begin
                if (!bus.sd_hndshk_i) begin
                    bb_d = bb_q + 9'd1;
                    if (bi_q == LAST_BI) begin
                        bi_d    = '0;
                        state_d = S_WRITE;
                    end else begin
                        bi_d    = bi_q + 2'd1;
                        state_d = S_BYTE_WAIT;
                    end
                end
            end
            S_WRITE: begin
                if (bus.ram_op_begun) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = (bb_q == 9'd0) ? S_FINISH : S_DRAIN;
                    end else begin
                        state_d = S_BYTE_WAIT;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.sd_hndshk_i) begin
                    state_d = S_DRAIN_ACK;
                end else if (!bus.sd_busy) begin
                    state_d = S_FINISH;
                end
            end
            S_DRAIN_ACK: begin
                if (!bus.sd_hndshk_i) begin
                    bb_d    = bb_q + 9'd1;
                    state_d = S_DRAIN;
                end
            end
            S_FINISH: begin
                if (!bus.sd_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_INIT;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them asynchronously.
    assign ready           = (state_q == S_IDLE);
    assign done            = (state_q == S_DONE);
    assign error           = (state_q == S_ERROR);
    assign err_code        = err_q;
    assign state_o         = state_q;
    assign bus.ram_we      = (state_q == S_WRITE);
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = word_q;
    assign bus.sd_rd       = (state_q == S_REQ);
    assign bus.sd_continue = (state_q == S_REQ) && cont_q;
    assign bus.sd_addr     = SDHC ? blk_q : {blk_q[22:0], 9'd0};
    assign bus.sd_hndshk_o = (state_q == S_BYTE_ACK) || (state_q == S_DRAIN_ACK);
endmodule

// File: tb/tb_sd_stream_loader.sv
// Directed bench for sd_stream_loader: a 16-bit big-endian SDHC instance and a 32-bit
// little-endian byte-addressed instance share one SD/RAM model selected by sel_b.
module tb_sd_stream_loader;
    localparam int AW = 25;
    localparam int EW = AW + 32;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          reset_n, start_a, start_b, sel_b, busy_m, hs_m, ack_en, ack_a, ack_b;
    logic [31:0]   src;
    logic [AW-1:0] dst, wc;
    logic [7:0]    data_m;
    logic [15:0]   err_m;
    logic          ready_a, done_a, error_a, ready_b, done_b, error_b;
    logic [15:0]   err_code_a, err_code_b;
    logic [3:0]    state_a, state_b;

    sd_stream_loader_if #(.ADDR_W(AW), .WORD_BYTES(2)) if_a ();
    sd_stream_loader_if #(.ADDR_W(AW), .WORD_BYTES(4)) if_b ();

    assign if_a.sd_busy      = busy_m & ~sel_b;
    assign if_a.sd_hndshk_i  = hs_m & ~sel_b;
    assign if_a.sd_data      = data_m;
    assign if_a.sd_error     = err_m;
    assign if_a.ram_op_begun = ack_a;
    assign if_b.sd_busy      = busy_m & sel_b;
    assign if_b.sd_hndshk_i  = hs_m & sel_b;
    assign if_b.sd_data      = data_m;
    assign if_b.sd_error     = 16'h0000;
    assign if_b.ram_op_begun = ack_b;

    wire          rd_m     = sel_b ? if_b.sd_rd       : if_a.sd_rd;
    wire          cont_m   = sel_b ? if_b.sd_continue : if_a.sd_continue;
    wire [31:0]   sdaddr_m = sel_b ? if_b.sd_addr     : if_a.sd_addr;
    wire          hso_m    = sel_b ? if_b.sd_hndshk_o : if_a.sd_hndshk_o;
    wire          we_m     = sel_b ? if_b.ram_we      : if_a.ram_we;
    wire [AW-1:0] waddr_m  = sel_b ? if_b.ram_address : if_a.ram_address;
    wire [31:0]   wdata_m  = sel_b ? if_b.ram_data    : {16'h0000, if_a.ram_data};
    wire          done_m   = sel_b ? done_b : done_a;

    sd_stream_loader #(.WORD_BYTES(2), .ADDR_W(AW), .SDHC(1'b1), .BIG_ENDIAN(1'b1)) dut_a (
        .clk50(clk), .reset_n(reset_n), .start(start_a), .src_block(src), .dst_addr(dst),
        .word_count(wc), .ready(ready_a), .done(done_a), .error(error_a),
        .err_code(err_code_a), .state_o(state_a), .bus(if_a));

    sd_stream_loader #(.WORD_BYTES(4), .ADDR_W(AW), .SDHC(1'b0), .BIG_ENDIAN(1'b0)) dut_b (
        .clk50(clk), .reset_n(reset_n), .start(start_b), .src_block(src), .dst_addr(dst),
        .word_count(wc), .ready(ready_b), .done(done_b), .error(error_b),
        .err_code(err_code_b), .state_o(state_b), .bus(if_b));

    // RAM arbiter model: one-cycle ram_op_begun per write, logging address/data.
    logic [EW-1:0] act_q[$];
    logic [EW-1:0] exp_q[$];
    int wr_cnt = 0, done_cnt = 0, rd_cnt = 0;

    always @(negedge clk) begin
        if (ack_en && we_m && !(sel_b ? ack_b : ack_a)) begin
            act_q.push_back({waddr_m, wdata_m});
            wr_cnt++;
            if (sel_b) ack_b <= 1'b1;
            else       ack_a <= 1'b1;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
        end
        if (done_m) done_cnt++;
        if (rd_m)   rd_cnt++;
    end

    int n_pass = 0, n_checks = 0;
    int act_rd = 0, drained = 0, wr_target = 0;
    int wr0, d0, r0;
    bit to_flag = 1'b0;
    logic [7:0]  blk_bytes[512];
    logic [31:0] req_addr;
    logic        req_cont;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_rd(output logic [31:0] a, output logic c);
        int k = 0;
        while (rd_m !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (rd_m !== 1'b1) chk("sd_rd timeout", 64'd0, 64'd1);
        a = sdaddr_m;
        c = cont_m;
        busy_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_bytes(input int first, input int n);
        int k;
        for (int i = first; i < first + n && !to_flag; i++) begin
            data_m = blk_bytes[i];
            hs_m   = 1'b1;
            k = 0;
            do begin @(negedge clk); k++; end while (hso_m !== 1'b1 && k < 200);
            if (hso_m !== 1'b1) begin to_flag = 1'b1; chk("ack rise timeout", 64'd0, 64'd1); end
            if (wr_cnt >= wr_target) drained++;
            hs_m = 1'b0;
            k = 0;
            do begin @(negedge clk); k++; end while (hso_m !== 1'b0 && k < 200);
            if (hso_m !== 1'b0) begin to_flag = 1'b1; chk("ack fall timeout", 64'd0, 64'd1); end
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_m !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (done_m !== 1'b1) chk(tag, 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic cmp_writes(input string tag);
        logic [EW-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_rd < act_q.size()) begin
                chk(tag, 64'(act_q[act_rd]), 64'(e));
                act_rd++;
            end else begin
                chk({tag, " missing"}, 64'd0, 64'd1);
            end
        end
        chk({tag, " extra"}, 64'(act_q.size() - act_rd), 64'd0);
        act_rd = act_q.size();
    endtask

    initial begin
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel_b = 1'b0;
        busy_m = 1'b0; hs_m = 1'b0; data_m = 8'h00; err_m = 16'h0000;
        ack_en = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
        src = '0; dst = '0; wc = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst ready", ready_a, 1'b0);
        chk("rst done", done_a, 1'b0);
        chk("rst error", error_a, 1'b0);
        chk("rst err_code", err_code_a, 16'h0);
        chk("rst ram_we", if_a.ram_we, 1'b0);
        chk("rst ram_address", if_a.ram_address, 25'h0);
        chk("rst sd_rd", if_a.sd_rd, 1'b0);
        chk("rst sd_addr", if_a.sd_addr, 32'h0);
        chk("rst hndshk_o", if_a.sd_hndshk_o, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("init->idle ready a", ready_a, 1'b1);
        chk("init->idle ready b", ready_b, 1'b1);

        // Exactly one block: 256 big-endian words
        for (int i = 0; i < 512; i++) blk_bytes[i] = 8'(i);
        src = 32'd5; dst = 25'h100; wc = 25'd256;
        wr0 = wr_cnt; d0 = done_cnt; drained = 0; wr_target = wr_cnt + 256;
        for (int w = 0; w < 256; w++)
            exp_q.push_back({25'h100 + 25'(w), 16'h0000, 8'(2 * w), 8'(2 * w + 1)});
        pulse_start(1'b0);
        wait_rd(req_addr, req_cont);
        chk("t1 sd_addr", req_addr, 32'd5);
        chk("t1 sd_continue", req_cont, 1'b0);
        chk("t1 sd_rd released", rd_m, 1'b0);
        send_bytes(0, 512);
        busy_m = 1'b0;
        wait_done("t1 done timeout");
        chk("t1 write count", 64'(wr_cnt - wr0), 64'd256);
        chk("t1 done pulses", 64'(done_cnt - d0), 64'd1);
        chk("t1 drained", 64'(drained), 64'd0);
        chk("t1 ready", ready_a, 1'b1);
        cmp_writes("t1 write");

        // Two blocks, 300 words, tail of block 6 drained
        src = 32'd5; dst = 25'h100; wc = 25'd300;
        wr0 = wr_cnt; d0 = done_cnt; drained = 0; wr_target = wr_cnt + 300;
        for (int w = 0; w < 256; w++)
            exp_q.push_back({25'h100 + 25'(w), 16'h0000, 8'(2 * w), 8'(2 * w + 1)});
        for (int w = 0; w < 44; w++)
            exp_q.push_back({25'h200 + 25'(w), 16'h0000, 8'(2 * w), 8'(2 * w + 1)});
        pulse_start(1'b0);
        wait_rd(req_addr, req_cont);
        chk("t2 first sd_addr", req_addr, 32'd5);
        chk("t2 first continue", req_cont, 1'b0);
        send_bytes(0, 512);
        busy_m = 1'b0;
        wait_rd(req_addr, req_cont);
        chk("t2 second sd_addr", req_addr, 32'd6);
        chk("t2 second continue", req_cont, 1'b1);
        send_bytes(0, 512);
        busy_m = 1'b0;
        wait_done("t2 done timeout");
        chk("t2 write count", 64'(wr_cnt - wr0), 64'd300);
        chk("t2 drained", 64'(drained), 64'd424);
        chk("t2 final address", waddr_m, 25'h22C);
        chk("t2 done pulses", 64'(done_cnt - d0), 64'd1);
        cmp_writes("t2 write");

        // Zero-length transfer
        r0 = rd_cnt; wc = '0;
        pulse_start(1'b0);
        chk("wc0 done", done_a, 1'b1);
        chk("wc0 ready low", ready_a, 1'b0);
        @(negedge clk);
        chk("wc0 done drop", done_a, 1'b0);
        chk("wc0 ready back", ready_a, 1'b1);
        repeat (3) @(negedge clk);
        chk("wc0 no sd_rd", 64'(rd_cnt - r0), 64'd0);

        // 32-bit little-endian, byte-addressed, single word
        sel_b = 1'b1;
        for (int i = 0; i < 512; i++) blk_bytes[i] = 8'h00;
        blk_bytes[0] = 8'h11; blk_bytes[1] = 8'h22; blk_bytes[2] = 8'h33; blk_bytes[3] = 8'h44;
        src = 32'd2; dst = 25'h40; wc = 25'd1;
        wr0 = wr_cnt; d0 = done_cnt; drained = 0; wr_target = wr_cnt + 1;
        exp_q.push_back({25'h40, 32'h44332211});
        pulse_start(1'b1);
        wait_rd(req_addr, req_cont);
        chk("t3 sd_addr", req_addr, 32'h400);
        chk("t3 sd_continue", req_cont, 1'b0);
        send_bytes(0, 512);
        busy_m = 1'b0;
        wait_done("t3 done timeout");
        chk("t3 drained", 64'(drained), 64'd508);
        chk("t3 write count", 64'(wr_cnt - wr0), 64'd1);
        chk("t3 done pulses", 64'(done_cnt - d0), 64'd1);
        cmp_writes("t3 write");
        sel_b = 1'b0;

        // Controller drops busy after 100 bytes
        for (int i = 0; i < 512; i++) blk_bytes[i] = 8'(i);
        src = 32'd9; dst = '0; wc = 25'd256;
        wr0 = wr_cnt; wr_target = wr_cnt + 256;
        pulse_start(1'b0);
        wait_rd(req_addr, req_cont);
        send_bytes(0, 100);
        busy_m = 1'b0;
        repeat (10) @(negedge clk);
        chk("proto error", error_a, 1'b1);
        chk("proto err_code", err_code_a, 16'h8000);
        chk("proto ready", ready_a, 1'b0);
        chk("proto writes", 64'(wr_cnt - wr0), 64'd50);
        act_rd = act_q.size();

        // Asynchronous reset while a write is pending
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst2 ready", ready_a, 1'b1);
        chk("rst2 error cleared", error_a, 1'b0);
        ack_en = 1'b0;
        blk_bytes[0] = 8'hAB; blk_bytes[1] = 8'hCD;
        src = 32'd1; dst = 25'h10; wc = 25'd4;
        pulse_start(1'b0);
        wait_rd(req_addr, req_cont);
        send_bytes(0, 2);
        chk("midw ram_we", we_m, 1'b1);
        chk("midw ram_address", waddr_m, 25'h10);
        chk("midw ram_data", wdata_m, 32'h0000ABCD);
        #2 reset_n = 1'b0;
        #1;
        chk("async ram_we", we_m, 1'b0);
        chk("async sd_rd", rd_m, 1'b0);
        chk("async hndshk_o", hso_m, 1'b0);
        chk("async ram_address", waddr_m, 25'h0);
        chk("async ram_data", wdata_m, 32'h0);
        chk("async sd_addr", sdaddr_m, 32'h0);
        chk("async ready", ready_a, 1'b0);
        chk("async error", error_a, 1'b0);
        busy_m = 1'b0;
        act_rd = act_q.size();
        @(negedge clk);
        reset_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        chk("rst3 ready", ready_a, 1'b1);

        // Controller error reported at init
        reset_n = 1'b0;
        err_m = 16'h0031;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("init err error", error_a, 1'b1);
        chk("init err code", err_code_a, 16'h0031);
        chk("init err ready", ready_a, 1'b0);
        r0 = rd_cnt; wc = 25'd4; src = 32'd3;
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        chk("err start ignored", error_a, 1'b1);
        chk("err no sd_rd", 64'(rd_cnt - r0), 64'd0);
        chk("err ready stays low", ready_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
